// File: rtl/alu_pkg.sv
// Shared encodings for the MIPS-style ALU: opcode/funct values, the internal
// operation set and the decoder's control bundle.
package alu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, LUI, NONE
  } alu_op_t;

  typedef enum logic [1:0] {
    BSEL_REG, BSEL_SEXT, BSEL_ZEXT
  } bsel_t;

  typedef enum logic {
    SH_SHAMT, SH_REG
  } shsrc_t;

  typedef struct packed {
    alu_op_t op;
    bsel_t   bsel;
    shsrc_t  shsrc;
  } alu_ctrl_t;

endpackage

// File: rtl/alu_decode.sv
// Instruction decoder: maps opcode/funct to an ALU operation plus the
// operand-B and shift-amount source selects.
module alu_decode
  import alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output alu_ctrl_t  ctrl
);

  always_comb begin
    ctrl = '{op: NONE, bsel: BSEL_REG, shsrc: SH_SHAMT};
    unique case (opcode)
      OP_RTYPE: begin
        unique case (funct)
          FN_SLL:           ctrl.op = SLL;
          FN_SRL:           ctrl.op = SRL;
          FN_SRA:           ctrl.op = SRA;
          FN_SLLV: begin
            ctrl.op    = SLL;
            ctrl.shsrc = SH_REG;
          end
          FN_SRLV: begin
            ctrl.op    = SRL;
            ctrl.shsrc = SH_REG;
          end
          FN_SRAV: begin
            ctrl.op    = SRA;
            ctrl.shsrc = SH_REG;
          end
          FN_ADD, FN_ADDU:  ctrl.op = ADD;
          FN_SUB, FN_SUBU:  ctrl.op = SUB;
          FN_AND:           ctrl.op = AND;
          FN_OR:            ctrl.op = OR;
          FN_XOR:           ctrl.op = XOR;
          FN_NOR:           ctrl.op = NOR;
          FN_SLT:           ctrl.op = SLT;
          FN_SLTU:          ctrl.op = SLTU;
          default:          ctrl.op = NONE;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
        ctrl.op   = ADD;
        ctrl.bsel = BSEL_SEXT;
      end
      OP_SLTI: begin
        ctrl.op   = SLT;
        ctrl.bsel = BSEL_SEXT;
      end
      // sltiu compares against the sign-extended immediate, treated unsigned
      OP_SLTIU: begin
        ctrl.op   = SLTU;
        ctrl.bsel = BSEL_SEXT;
      end
      OP_ANDI: begin
        ctrl.op   = AND;
        ctrl.bsel = BSEL_ZEXT;
      end
      OP_ORI: begin
        ctrl.op   = OR;
        ctrl.bsel = BSEL_ZEXT;
      end
      OP_XORI: begin
        ctrl.op   = XOR;
        ctrl.bsel = BSEL_ZEXT;
      end
      OP_LUI:           ctrl.op = LUI;
      OP_BEQ, OP_BNE:   ctrl.op = SUB;
      default:          ctrl.op = NONE;
    endcase
  end

endmodule

// File: rtl/mips_alu.sv
// Registered MIPS-style ALU: decodes the instruction word, computes the
// result combinationally and registers c/zero one clock later.
module mips_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instruction,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             zero
);

  alu_ctrl_t        ctrl;
  logic [15:0]      imm;
  logic [4:0]       sh;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] next_c;
  logic             lt;
  logic             unused_rs_rt;

  assign imm = instruction[15:0];
  // rs/rt register numbers are resolved upstream; only their values arrive here
  assign unused_rs_rt = ^instruction[25:16];

  alu_decode u_decode (
    .opcode (instruction[31:26]),
    .funct  (instruction[5:0]),
    .ctrl   (ctrl)
  );

  always_comb begin
    unique case (ctrl.bsel)
      BSEL_SEXT: opb = {{(WIDTH-16){imm[15]}}, imm};
      BSEL_ZEXT: opb = {{(WIDTH-16){1'b0}}, imm};
      default:   opb = b;
    endcase
  end

  assign sh = (ctrl.shsrc == SH_REG) ? a[4:0] : instruction[10:6];

  always_comb begin
    lt     = 1'b0;
    next_c = '0;
    unique case (ctrl.op)
      ADD:  next_c = a + opb;
      SUB:  next_c = a - opb;
      AND:  next_c = a & opb;
      OR:   next_c = a | opb;
      XOR:  next_c = a ^ opb;
      NOR:  next_c = ~(a | opb);
      SLT: begin
        lt     = $signed(a) < $signed(opb);
        next_c = {{(WIDTH-1){1'b0}}, lt};
      end
      SLTU: begin
        lt     = a < opb;
        next_c = {{(WIDTH-1){1'b0}}, lt};
      end
      SLL:  next_c = b << sh;
      SRL:  next_c = b >> sh;
      SRA:  next_c = $signed(b) >>> sh;
      LUI:  next_c = {imm, {(WIDTH-16){1'b0}}};
      default: next_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c    <= '0;
      zero <= 1'b1;
    end else begin
      c    <= next_c;
      zero <= (next_c == '0);
    end
  end

endmodule

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu: directed vector table, reset sequences,
// and a randomized back-to-back stream against a behavioural model.
module tb_mips_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction, a, b, c;
  logic        zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mips_alu #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .a           (a),
    .b           (b),
    .c           (c),
    .zero        (zero)
  );

  typedef struct {
    string       name;
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_c;
    logic        exp_z;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] rt(input logic [5:0] fn, input logic [4:0] shamt);
    return {6'h00, 5'd1, 5'd2, 5'd3, shamt, fn};
  endfunction

  function automatic logic [31:0] it(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd1, 5'd2, imm};
  endfunction

  // Reference model built straight from the instruction-set rules.
  function automatic logic [31:0] ref_c(input logic [31:0] ins, input logic [31:0] ra,
                                        input logic [31:0] rb);
    logic [5:0]  op, fn;
    logic [4:0]  shamt;
    logic [31:0] se, ze, r;
    int          sa, sb, si;
    op    = ins[31:26];
    fn    = ins[5:0];
    shamt = ins[10:6];
    se    = {{16{ins[15]}}, ins[15:0]};
    ze    = {16'h0000, ins[15:0]};
    sa    = ra;
    sb    = rb;
    si    = se;
    r     = 32'h0;
    if (op == 6'h00) begin
      case (fn)
        6'h00: r = rb << shamt;
        6'h02: r = rb >> shamt;
        6'h03: r = (rb >> shamt) | (rb[31] ? ~(32'hFFFF_FFFF >> shamt) : 32'h0);
        6'h04: r = rb << ra[4:0];
        6'h06: r = rb >> ra[4:0];
        6'h07: r = (rb >> ra[4:0]) | (rb[31] ? ~(32'hFFFF_FFFF >> ra[4:0]) : 32'h0);
        6'h20, 6'h21: r = 32'(64'(ra) + 64'(rb));
        6'h22, 6'h23: r = 32'(64'(ra) + 64'(~rb) + 64'd1);
        6'h24: r = ra & rb;
        6'h25: r = ra | rb;
        6'h26: r = ra ^ rb;
        6'h27: r = ~(ra | rb);
        6'h2A: r = (sa < sb) ? 32'd1 : 32'd0;
        6'h2B: r = (ra < rb) ? 32'd1 : 32'd0;
        default: r = 32'h0;
      endcase
    end else begin
      case (op)
        6'h08, 6'h09, 6'h23, 6'h2B: r = 32'(64'(ra) + 64'(se));
        6'h0A: r = (sa < si) ? 32'd1 : 32'd0;
        6'h0B: r = (ra < se) ? 32'd1 : 32'd0;
        6'h0C: r = ra & ze;
        6'h0D: r = ra | ze;
        6'h0E: r = ra ^ ze;
        6'h0F: r = ins[15:0] * 32'h0001_0000;
        6'h04, 6'h05: r = 32'(64'(ra) + 64'(~rb) + 64'd1);
        default: r = 32'h0;
      endcase
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] exp_c, input logic exp_z);
    n_checks++;
    if (c !== exp_c) begin
      n_fail++;
      $display("FAIL %s: c=%h expected %h (t=%0t)", name, c, exp_c, $time);
    end
    n_checks++;
    if (zero !== exp_z) begin
      n_fail++;
      $display("FAIL %s: zero=%b expected %b (t=%0t)", name, zero, exp_z, $time);
    end
  endtask

  task automatic step(input logic [31:0] ins, input logic [31:0] ra, input logic [31:0] rb);
    instruction = ins;
    a           = ra;
    b           = rb;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [5:0]  ops[13];
  logic [5:0]  fns[16];
  logic [31:0] prev_c, ins, ra, rb, exp;

  initial begin
    ops = '{6'h00, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
            6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
    fns = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
            6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

    vecs.push_back('{"add_wrap",  rt(6'h20, 5'd0), 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0});
    vecs.push_back('{"sub",       rt(6'h22, 5'd0), 32'h7FFF_FFFF, 32'h1, 32'h7FFF_FFFE, 1'b0});
    vecs.push_back('{"nor",       rt(6'h27, 5'd0), 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0});
    vecs.push_back('{"slt",       rt(6'h2A, 5'd0), 32'hFFFF_FFFF, 32'h1, 32'h1,         1'b0});
    vecs.push_back('{"sltu",      rt(6'h2B, 5'd0), 32'hFFFF_FFFF, 32'h1, 32'h0,         1'b1});
    vecs.push_back('{"sra4",      rt(6'h03, 5'd4), 32'h0, 32'h8000_0000, 32'hF800_0000, 1'b0});
    vecs.push_back('{"srl4",      rt(6'h02, 5'd4), 32'h0, 32'h8000_0000, 32'h0800_0000, 1'b0});
    vecs.push_back('{"sllv35",    rt(6'h04, 5'd0), 32'd35, 32'h1, 32'h8,                1'b0});
    vecs.push_back('{"srav36",    rt(6'h07, 5'd0), 32'd36, 32'h8000_0000, 32'hF800_0000, 1'b0});
    vecs.push_back('{"srlv4",     rt(6'h06, 5'd0), 32'd4, 32'h8000_0000, 32'h0800_0000, 1'b0});
    vecs.push_back('{"sll31",     rt(6'h00, 5'd31), 32'h0, 32'h1, 32'h8000_0000,        1'b0});
    vecs.push_back('{"addi_neg",  it(6'h08, 16'hFFFF), 32'h10, 32'h0, 32'h0000_000F,    1'b0});
    vecs.push_back('{"ori_zext",  it(6'h0D, 16'hFFFF), 32'h10, 32'h0, 32'h0000_FFFF,    1'b0});
    vecs.push_back('{"lui",       it(6'h0F, 16'h1234), 32'h10, 32'h0, 32'h1234_0000,    1'b0});
    vecs.push_back('{"sltiu",     it(6'h0B, 16'hFFFF), 32'h10, 32'h0, 32'h1,           1'b0});
    vecs.push_back('{"slti",      it(6'h0A, 16'hFFFF), 32'hFFFF_FFFE, 32'h0, 32'h1,     1'b0});
    vecs.push_back('{"andi",      it(6'h0C, 16'h0FF0), 32'hFFFF_F0F0, 32'h0, 32'h0000_00F0, 1'b0});
    vecs.push_back('{"xori",      it(6'h0E, 16'hFFFF), 32'hFFFF_0000, 32'h0, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{"lw",        it(6'h23, 16'hFFFC), 32'h100, 32'h0, 32'h0000_00FC,   1'b0});
    vecs.push_back('{"sw",        it(6'h2B, 16'h0008), 32'h100, 32'h0, 32'h0000_0108,   1'b0});
    vecs.push_back('{"beq_eq",    it(6'h04, 16'h0010), 32'd5, 32'd5, 32'h0,             1'b1});
    vecs.push_back('{"bne_ne",    it(6'h05, 16'h0010), 32'd5, 32'd3, 32'h2,             1'b0});
    vecs.push_back('{"bad_op",    it(6'h3F, 16'h1234), 32'd5, 32'd3, 32'h0,             1'b1});
    vecs.push_back('{"bad_funct", rt(6'h3F, 5'd0), 32'd5, 32'd3, 32'h0,                 1'b1});

    // Reset, then sll with shamt 0 passes b through.
    rst = 1'b1;
    step(32'h0000_0000, 32'd2, 32'd1);
    check("reset", 32'h0, 1'b1);
    rst = 1'b0;
    step(32'h0000_0000, 32'd2, 32'd1);
    check("sll0_after_reset", 32'h1, 1'b0);

    foreach (vecs[i]) begin
      step(vecs[i].ins, vecs[i].a, vecs[i].b);
      check(vecs[i].name, vecs[i].exp_c, vecs[i].exp_z);
    end
    prev_c = vecs[vecs.size()-1].exp_c;

    // Back-to-back random stream: old result must hold until the edge,
    // the new one must appear right after it.
    for (int i = 0; i < 300; i++) begin
      ins = $urandom;
      if ($urandom_range(0, 9) != 0) ins[31:26] = ops[$urandom_range(0, 12)];
      if (ins[31:26] == 6'h00 && $urandom_range(0, 9) != 0) ins[5:0] = fns[$urandom_range(0, 15)];
      case ($urandom_range(0, 3))
        0:       begin ra = $urandom; rb = ra; end
        1:       begin ra = $urandom_range(0, 40); rb = $urandom; end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      instruction = ins;
      a           = ra;
      b           = rb;
      #1;
      check("hold", prev_c, prev_c == 32'h0);
      exp = ref_c(ins, ra, rb);
      @(posedge clk);
      #1;
      check("rand", exp, exp == 32'h0);
      prev_c = exp;
    end

    // Reset in the middle of a stream overrides a nonzero computation.
    step(rt(6'h20, 5'd0), 32'd7, 32'd9);
    check("pre_reset", 32'd16, 1'b0);
    rst = 1'b1;
    step(rt(6'h25, 5'd0), 32'hFFFF_0000, 32'h0000_FFFF);
    check("mid_reset", 32'h0, 1'b1);
    rst = 1'b0;
    step(it(6'h0F, 16'hABCD), 32'h0, 32'h0);
    check("post_reset", 32'hABCD_0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_alu.md
Name:
mips_alu

Overview:
- Registered 32-bit ALU for the single-cycle/pipelined MIPS-style datapath.
- Decodes the full 32-bit instruction word itself, from opcode [31:26] and funct [5:0].
- Combines register operands a/b with the instruction's shamt or immediate.
- Produces result c and flag zero, one clock after the inputs are presented.

Parameters:
- WIDTH, 32, data width of a, b and c (only 32 is required to be supported).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- instruction  input  32  instruction word; opcode=[31:26], shamt=[10:6], funct=[5:0], imm=[15:0]
- a  input  32  operand A (rs value)
- b  input  32  operand B (rt value)
- c  output  32  registered result
- zero  output  1  registered flag, 1 when the registered c equals 0

Behaviour:
- Reset: synchronous; at a rising clk with rst=1, c<=0 and zero<=1. rst has priority over any computation.
- Latency: exactly 1 cycle. Inputs sampled at rising clk; c/zero are valid after that edge and hold until the next edge. No handshake; a new operation is accepted every cycle.
- zero is always computed from the same next-result value as c: zero <= (next_c == 0).
- Immediate extension:
  - sext = {{16{imm[15]}}, imm}
  - zext = {16'b0, imm}
- R-type (opcode 0x00), selected by funct:
  - 0x00 sll: b<<shamt
  - 0x02 srl: b>>shamt, logical
  - 0x03 sra: b>>>shamt, arithmetic
  - 0x04 sllv: b<<a[4:0]
  - 0x06 srlv: b>>a[4:0], logical
  - 0x07 srav: b>>>a[4:0], arithmetic
  - 0x20 add / 0x21 addu: a+b
  - 0x22 sub / 0x23 subu: a-b
  - 0x24 and: a&b
  - 0x25 or: a|b
  - 0x26 xor: a^b
  - 0x27 nor: ~(a|b)
  - 0x2A slt: signed a<b → 1, else 0
  - 0x2B sltu: unsigned a<b → 1, else 0
  - Any other funct → c=0.
- I-type, selected by opcode:
  - 0x08 addi / 0x09 addiu: a+sext
  - 0x0A slti: signed a<sext
  - 0x0B sltiu: unsigned a<sext
  - 0x0C andi: a&zext
  - 0x0D ori: a|zext
  - 0x0E xori: a^zext
  - 0x0F lui: {imm,16'b0}
  - 0x23 lw / 0x2B sw: a+sext (address)
  - 0x04 beq / 0x05 bne: a-b, so zero=1 when equal. Branch decision is outside this block.
  - Any other opcode → c=0 (zero=1).
- Arithmetic: all add/sub wrap modulo 2^32. Signed overflow is ignored; no trap, no flag.
- Shift amounts use only 5 bits; shamt 0 passes b through unchanged.
- Purely combinational next-state feeding one output register; no other state.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams (OP_RTYPE, OP_ADDI, …, OP_LW, OP_SW, OP_BEQ, OP_BNE);
  - funct localparams (FN_SLL … FN_SLTU);
  - an enum alu_op_t (ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, LUI, NONE).
- One natural sub-module, alu_decode, maps instruction → {alu_op_t, operand-B select (reg/sext/zext), shift-source select (shamt/a)}.
- mips_alu instantiates alu_decode and holds the datapath and output register.

Test Plan:
- Reset and default shift:
  - Stimulus: rst=1 for one edge; then rst=0, a=2, b=1, instruction=0x00000000 (sll, shamt 0).
  - Required: during reset c=0, zero=1; after the next edge c=1, zero=0.
- R-type arithmetic and logic, a=0x7FFFFFFF, b=1:
  - add (funct 0x20) → c=0x80000000, no trap.
  - sub → 0x7FFFFFFE.
  - nor → 0x80000000 & ~1 = 0x80000000.
  - slt with a=-1, b=1 → 1.
  - sltu with a=-1, b=1 → 0.
- Shifts, b=0x80000000:
  - sra shamt 4 → 0xF8000000.
  - srl shamt 4 → 0x08000000.
  - sllv with a=35 (uses 3) and b=1 → 8.
- Immediates, a=0x10:
  - addi imm=0xFFFF → 0x0F.
  - ori imm=0xFFFF → 0x0000FFFF.
  - lui imm=0x1234 → 0x12340000.
  - sltiu imm=0xFFFF → 1.
- Branch/zero:
  - beq with a=b=5 → c=0, zero=1.
  - bne with a=5, b=3 → c=2, zero=0.
  - Unknown opcode 0x3F → c=0, zero=1.
- Back-to-back and reset mid-stream:
  - Change the instruction every cycle; each result must appear exactly one edge later.
  - Assert rst during a stream; c=0, zero=1 at that edge, regardless of the inputs.
